// File: rtl/life_event_arbiter_if.sv
// Event/command bundle between the gameplay logic, the arbiter and the life tracker.
// Carries raw event pulses and the life feedback in; one-hot commands and status out.
// No handshake: every pulse is a single-cycle strobe sampled on the clock edge.
interface life_event_arbiter_if;
  logic       startOfFrame;
  logic       hitEnemy;
  logic       hitSpell;
  logic       pickupPotion;
  logic       levelStart;
  logic [2:0] currLife;
  logic [2:0] amount;
  logic       enableSetLife;
  logic       enableAddLife;
  logic       enableRemoveLife;
  logic       invulnerable;
  logic       blink;
  logic       gameOver;

  // Environment side: produces events and life feedback, consumes commands.
  modport master (
    output startOfFrame, hitEnemy, hitSpell, pickupPotion, levelStart, currLife,
    input  amount, enableSetLife, enableAddLife, enableRemoveLife, invulnerable, blink, gameOver
  );

  // Arbiter side.
  modport slave (
    input  startOfFrame, hitEnemy, hitSpell, pickupPotion, levelStart, currLife,
    output amount, enableSetLife, enableAddLife, enableRemoveLife, invulnerable, blink, gameOver
  );
endinterface

// File: rtl/life_event_arbiter.sv
// Turns gameplay events into one-hot set/add/remove life commands with invulnerability and heal clamp.
// Latency: event -> pending 1 cycle, pending -> command 1 cycle when idle; commands spaced >= 3 cycles.
// No backpressure: events are accumulated (saturating) while a command settles, or dropped when gated.
module life_event_arbiter #(
  parameter int START_LIFE    = 3,
  parameter int MAX_LIFE      = 5,
  parameter int ENEMY_DMG     = 1,
  parameter int SPELL_DMG     = 2,
  parameter int POTION_HEAL   = 1,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 4
) (
  input  logic                clk,
  input  logic                resetN,
  life_event_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [2:0]       START_L  = 3'(START_LIFE);
  localparam logic [2:0]       MAX_L    = 3'(MAX_LIFE);
  localparam logic [4:0]       ENEMY_D  = 5'(ENEMY_DMG);
  localparam logic [4:0]       SPELL_D  = 5'(SPELL_DMG);
  localparam logic [4:0]       POTION_H = 5'(POTION_HEAL);
  localparam logic [CNT_W-1:0] INV_LOAD = CNT_W'(INVULN_FRAMES);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_pendStart;
  logic [2:0]       r_pendDmg;
  logic [2:0]       r_pendHeal;
  logic [CNT_W-1:0] r_invCnt;
  logic [BLK_W-1:0] r_blinkCnt;
  logic             r_blinkPhase;
  logic [2:0]       r_amount;
  logic             r_enSet;
  logic             r_enAdd;
  logic             r_enRem;
  logic             r_gameOver;

  logic             w_invuln;
  logic             w_idle;
  logic             w_takeStart;
  logic             w_takeDmg;
  logic             w_takeHeal;
  logic             w_hitOk;
  logic             w_potOk;
  logic [2:0]       w_room;
  logic [2:0]       w_healAmt;
  logic [4:0]       w_dmgIn;
  logic [4:0]       w_dmgSum;
  logic [4:0]       w_healSum;

  assign w_invuln = (r_invCnt != '0);
  assign w_idle   = (r_state == IDLE);

  // Priority start > damage > heal; damage waits out invulnerability, nothing but start after game over.
  assign w_takeStart = w_idle && r_pendStart;
  assign w_takeDmg   = w_idle && !r_pendStart && (r_pendDmg != 3'd0) && !w_invuln && !r_gameOver;
  assign w_takeHeal  = w_idle && !r_pendStart && !w_takeDmg && (r_pendHeal != 3'd0) && !r_gameOver;

  // Heal never pushes life above the ceiling; a full player simply loses the pending heal.
  assign w_room    = (bus.currLife >= MAX_L) ? 3'd0 : (MAX_L - bus.currLife);
  assign w_healAmt = (r_pendHeal < w_room) ? r_pendHeal : w_room;

  // Gating uses the registered status, so a hit in the cycle a REMOVE issues still counts.
  assign w_hitOk = !w_invuln && !r_gameOver;
  assign w_potOk = !r_gameOver;

  assign w_dmgIn   = (bus.hitEnemy ? ENEMY_D : 5'd0) + (bus.hitSpell ? SPELL_D : 5'd0);
  assign w_dmgSum  = ((w_takeStart || w_takeDmg) ? 5'd0 : {2'b00, r_pendDmg})
                   + (w_hitOk ? w_dmgIn : 5'd0);
  assign w_healSum = ((w_takeStart || w_takeHeal) ? 5'd0 : {2'b00, r_pendHeal})
                   + ((w_potOk && bus.pickupPotion) ? POTION_H : 5'd0);

  // Pending capture: consume first, then add this cycle's events so nothing arriving now is lost.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pendStart <= 1'b0;
      r_pendDmg   <= 3'd0;
      r_pendHeal  <= 3'd0;
    end else begin
      r_pendStart <= bus.levelStart || (r_pendStart && !w_takeStart);
      r_pendDmg   <= (w_dmgSum > 5'd7) ? 3'd7 : w_dmgSum[2:0];
      r_pendHeal  <= (w_healSum > 5'd7) ? 3'd7 : w_healSum[2:0];
    end
  end

  // Command FSM with registered one-hot enables, amount and sticky game-over flag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_amount   <= 3'd0;
      r_enSet    <= 1'b0;
      r_enAdd    <= 1'b0;
      r_enRem    <= 1'b0;
      r_gameOver <= 1'b0;
    end else begin
      r_amount <= 3'd0;
      r_enSet  <= 1'b0;
      r_enAdd  <= 1'b0;
      r_enRem  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_takeStart) begin
            r_enSet    <= 1'b1;
            r_amount   <= START_L;
            r_gameOver <= 1'b0;
            r_state    <= SETTLE;
          end else if (w_takeDmg) begin
            r_enRem  <= 1'b1;
            r_amount <= r_pendDmg;
            r_state  <= SETTLE;
          end else if (w_takeHeal && (w_healAmt != 3'd0)) begin
            r_enAdd  <= 1'b1;
            r_amount <= w_healAmt;
            r_state  <= SETTLE;
          end
        end
        SETTLE: r_state <= CHECK;
        CHECK: begin
          if (bus.currLife == 3'd0) r_gameOver <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Invulnerability frame counter and blink phase; a REMOVE restarts both, a SET cancels them.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_invCnt     <= '0;
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (w_takeDmg) begin
      r_invCnt     <= INV_LOAD;
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b1;
    end else if (w_takeStart) begin
      r_invCnt     <= '0;
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (bus.startOfFrame && w_invuln) begin
      r_invCnt <= r_invCnt - CNT_W'(1);
      if (r_blinkCnt == BLK_LAST) begin
        r_blinkCnt   <= '0;
        r_blinkPhase <= ~r_blinkPhase;
      end else begin
        r_blinkCnt <= r_blinkCnt + BLK_W'(1);
      end
    end
  end

  assign bus.amount           = r_amount;
  assign bus.enableSetLife    = r_enSet;
  assign bus.enableAddLife    = r_enAdd;
  assign bus.enableRemoveLife = r_enRem;
  assign bus.invulnerable     = w_invuln;
  assign bus.blink            = r_blinkPhase && w_invuln;
  assign bus.gameOver         = r_gameOver;

endmodule

// File: tb/tb_life_event_arbiter.sv
// Bench for life_event_arbiter: directed scenarios plus random events against a behavioural model.
// The bench also plays the life tracker, applying each predicted command to its own life value.
// Outputs are sampled on the falling edge; inputs change right after it.
module tb_life_event_arbiter;
  localparam int START_LIFE    = 3;
  localparam int MAX_LIFE      = 5;
  localparam int ENEMY_DMG     = 1;
  localparam int SPELL_DMG     = 2;
  localparam int POTION_HEAL   = 1;
  localparam int INVULN_FRAMES = 60;
  localparam int BLINK_FRAMES  = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  life_event_arbiter_if bus();

  life_event_arbiter #(
    .START_LIFE(START_LIFE), .MAX_LIFE(MAX_LIFE), .ENEMY_DMG(ENEMY_DMG), .SPELL_DMG(SPELL_DMG),
    .POTION_HEAL(POTION_HEAL), .INVULN_FRAMES(INVULN_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model state: life held by the tracker, pending work, frames of invulnerability left,
  // frames elapsed since the last hit, cycles until the arbiter can act, last command (0 none,1 set,2 add,3 remove).
  int m_life, m_pstart, m_pdmg, m_pheal, m_inv, m_sof, m_go, m_busy, m_cmd, m_amt;

  function automatic logic [8:0] dut_vec();
    return {bus.amount, bus.enableSetLife, bus.enableAddLife, bus.enableRemoveLife,
            bus.invulnerable, bus.blink, bus.gameOver};
  endfunction

  function automatic logic [8:0] mdl_vec();
    logic inv;
    logic blk;
    inv = (m_inv != 0);
    blk = inv && (((m_sof / BLINK_FRAMES) % 2) == 0);
    return {3'(m_amt), m_cmd == 1, m_cmd == 2, m_cmd == 3, inv, blk, m_go != 0};
  endfunction

  task automatic model_reset();
    m_pstart = 0; m_pdmg = 0; m_pheal = 0; m_inv = 0; m_sof = 0;
    m_go = 0; m_busy = 0; m_cmd = 0; m_amt = 0;
  endtask

  task automatic model_edge(input bit sof, input bit he, input bit hs, input bit pp, input bit ls);
    int life_in, cmd, amt, room, sum;
    bit inv, go, took_start, took_heal;
    life_in = m_life; inv = (m_inv != 0); go = (m_go != 0);
    took_start = 0; took_heal = 0; cmd = 0; amt = 0;
    if (m_busy == 0) begin
      if (m_pstart != 0) begin
        cmd = 1; amt = START_LIFE; took_start = 1;
      end else if (m_pdmg != 0 && !inv && !go) begin
        cmd = 3; amt = m_pdmg;
      end else if (m_pheal != 0 && !go) begin
        room = (life_in >= MAX_LIFE) ? 0 : MAX_LIFE - life_in;
        amt = (m_pheal < room) ? m_pheal : room;
        took_heal = 1;
        if (amt != 0) cmd = 2;
      end
    end
    case (m_cmd)
      1: m_life = m_amt;
      2: m_life = (m_life + m_amt > 7) ? 7 : m_life + m_amt;
      3: m_life = (m_life > m_amt) ? m_life - m_amt : 0;
      default: ;
    endcase
    if (m_busy == 1 && life_in == 0) m_go = 1;
    if (cmd == 1) m_go = 0;
    if (m_busy > 0) m_busy--; else if (cmd != 0) m_busy = 2;
    if (took_start) begin m_pstart = 0; m_pdmg = 0; m_pheal = 0; end
    if (cmd == 3) m_pdmg = 0;
    if (took_heal) m_pheal = 0;
    if (ls) m_pstart = 1;
    if (!inv && !go) begin
      sum = m_pdmg + (he ? ENEMY_DMG : 0) + (hs ? SPELL_DMG : 0);
      m_pdmg = (sum > 7) ? 7 : sum;
    end
    if (!go && pp) m_pheal = (m_pheal + POTION_HEAL > 7) ? 7 : m_pheal + POTION_HEAL;
    if (cmd == 3) begin m_inv = INVULN_FRAMES; m_sof = 0; end
    else if (cmd == 1) m_inv = 0;
    else if (sof && m_inv > 0) begin m_inv--; m_sof++; end
    m_cmd = cmd;
    m_amt = (cmd != 0) ? amt : 0;
  endtask

  // One clock: drive events and tracker life, advance the model at the edge, return at the falling edge.
  task automatic step(input bit sof, input bit he, input bit hs, input bit pp, input bit ls);
    bus.startOfFrame = sof; bus.hitEnemy = he; bus.hitSpell = hs;
    bus.pickupPotion = pp; bus.levelStart = ls; bus.currLife = 3'(m_life);
    @(posedge clk);
    model_edge(sof, he, hs, pp, ls);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.startOfFrame = 0; bus.hitEnemy = 0; bus.hitSpell = 0;
    bus.pickupPotion = 0; bus.levelStart = 0; bus.currLife = 3'(m_life);
    #2 resetN = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    m_life = 3;
    bus.currLife = 3'd3;
    #2 resetN = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 9'd0) $display("FAIL reset_outputs: got %b expected %b", dut_vec(), 9'd0);
    else passes++;
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec() !== 9'd0) $display("FAIL reset_no_set cyc%0d: got %b expected %b", i, dut_vec(), 9'd0);
      else passes++;
    end
  endtask

  task automatic test_enemy_hit();
    int sofs;
    sofs = 0;
    m_life = 3;
    apply_reset();
    step(0, 1, 0, 0, 0);
    checks++;
    if (dut_vec() !== 9'd0) $display("FAIL enemy_latency1: got %b expected %b", dut_vec(), 9'd0);
    else passes++;
    step(0, 0, 0, 0, 0);
    checks++;
    if ({bus.enableRemoveLife, bus.amount, bus.invulnerable, bus.blink} !== {1'b1, 3'd1, 1'b1, 1'b1})
      $display("FAIL enemy_remove: got rem=%b amt=%0d inv=%b blk=%b expected rem=1 amt=1 inv=1 blk=1",
               bus.enableRemoveLife, bus.amount, bus.invulnerable, bus.blink);
    else passes++;
    for (int i = 0; i < 130; i++) begin
      step(i % 2 == 0, 0, 0, 0, 0);
      if (i % 2 == 0) sofs++;
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL enemy_window cyc%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      else passes++;
      if (i % 2 == 0 && sofs == INVULN_FRAMES - 1) begin
        checks++;
        if (bus.invulnerable !== 1'b1) $display("FAIL enemy_inv_59: got %b expected 1", bus.invulnerable);
        else passes++;
      end
      if (i % 2 == 0 && sofs == INVULN_FRAMES) begin
        checks++;
        if (bus.invulnerable !== 1'b0 || bus.blink !== 1'b0)
          $display("FAIL enemy_inv_60: got inv=%b blk=%b expected 0 0", bus.invulnerable, bus.blink);
        else passes++;
      end
    end
  endtask

  task automatic test_double_hit();
    m_life = 5;
    apply_reset();
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if ({bus.enableRemoveLife, bus.amount} !== {1'b1, 3'd3})
      $display("FAIL double_remove: got rem=%b amt=%0d expected rem=1 amt=3", bus.enableRemoveLife, bus.amount);
    else passes++;
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if ({bus.enableSetLife, bus.enableAddLife, bus.enableRemoveLife} !== 3'b000 || dut_vec() !== mdl_vec())
        $display("FAIL double_ignored cyc%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      else passes++;
    end
  endtask

  task automatic test_potion_clamp();
    int adds, amt_seen;
    m_life = 4;
    apply_reset();
    adds = 0; amt_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, i < 3, 0);
      if (bus.enableAddLife === 1'b1) begin adds++; amt_seen = int'(bus.amount); end
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL potion_cycle cyc%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      else passes++;
    end
    checks++;
    if (adds != 1 || amt_seen != 1) $display("FAIL potion_clamp: got adds=%0d amt=%0d expected adds=1 amt=1", adds, amt_seen);
    else passes++;
    adds = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, i < 2, 0);
      if (bus.enableAddLife === 1'b1) adds++;
    end
    checks++;
    if (adds != 0) $display("FAIL potion_full: got adds=%0d expected 0", adds);
    else passes++;
  endtask

  task automatic test_game_over();
    int cmds;
    m_life = 2;
    apply_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if ({bus.enableRemoveLife, bus.amount} !== {1'b1, 3'd2})
      $display("FAIL over_remove: got rem=%b amt=%0d expected rem=1 amt=2", bus.enableRemoveLife, bus.amount);
    else passes++;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (bus.gameOver !== 1'b1) $display("FAIL over_set: got %b expected 1", bus.gameOver);
    else passes++;
    cmds = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, i % 3 == 0, i % 3 == 1, i % 3 == 2, 0);
      if (bus.enableSetLife || bus.enableAddLife || bus.enableRemoveLife) cmds++;
    end
    checks++;
    if (cmds != 0 || bus.gameOver !== 1'b1)
      $display("FAIL over_ignore: got cmds=%0d over=%b expected cmds=0 over=1", cmds, bus.gameOver);
    else passes++;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    checks++;
    if ({bus.enableSetLife, bus.amount, bus.gameOver, bus.invulnerable} !== {1'b1, 3'd3, 1'b0, 1'b0})
      $display("FAIL over_restart: got set=%b amt=%0d over=%b inv=%b expected set=1 amt=3 over=0 inv=0",
               bus.enableSetLife, bus.amount, bus.gameOver, bus.invulnerable);
    else passes++;
  endtask

  task automatic test_simultaneous();
    int cmds;
    m_life = 3;
    apply_reset();
    step(0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    checks++;
    if ({bus.enableSetLife, bus.enableAddLife, bus.enableRemoveLife, bus.amount} !== {3'b100, 3'd3})
      $display("FAIL simul_set: got %b expected %b",
               {bus.enableSetLife, bus.enableAddLife, bus.enableRemoveLife, bus.amount}, {3'b100, 3'd3});
    else passes++;
    cmds = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0);
      if (bus.enableSetLife || bus.enableAddLife || bus.enableRemoveLife || bus.invulnerable) cmds++;
    end
    checks++;
    if (cmds != 0) $display("FAIL simul_dropped: got %0d active cycles expected 0", cmds);
    else passes++;
  endtask

  task automatic test_reset_mid();
    m_life = 4;
    apply_reset();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if ({bus.enableRemoveLife, bus.invulnerable} !== 2'b11)
      $display("FAIL midrst_setup: got rem=%b inv=%b expected 1 1", bus.enableRemoveLife, bus.invulnerable);
    else passes++;
    #2 resetN = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 9'd0) $display("FAIL midrst_outputs: got %b expected %b", dut_vec(), 9'd0);
    else passes++;
    @(negedge clk);
    resetN = 1'b1;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if ({bus.enableRemoveLife, bus.amount} !== {1'b1, 3'd1})
      $display("FAIL midrst_after: got rem=%b amt=%0d expected rem=1 amt=1", bus.enableRemoveLife, bus.amount);
    else passes++;
  endtask

  task automatic test_random();
    bit sof, he, hs, pp, ls;
    int bad;
    bad = 0;
    m_life = 3;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      sof = ($urandom_range(0, 2) == 0);
      he  = ($urandom_range(0, 9) == 0);
      hs  = ($urandom_range(0, 14) == 0);
      pp  = ($urandom_range(0, 5) == 0);
      ls  = ($urandom_range(0, 149) == 0) || (m_go != 0 && $urandom_range(0, 19) == 0);
      step(sof, he, hs, pp, ls);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        if (bad < 10) $display("FAIL random cyc%0d: got %b expected %b", i, dut_vec(), mdl_vec());
        bad++;
      end else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_enemy_hit();
    test_double_hit();
    test_potion_clamp();
    test_game_over();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/life_event_arbiter.md
Name: life_event_arbiter

Overview:
- Upstream stage of the player life tracker. It converts raw gameplay events (enemy hit, spell hit, potion pickup, level start) into single-cycle set/add/remove commands with an amount.
- Enforces a post-hit invulnerability window and clamps healing to MAX_LIFE.
- Reads back current life to raise gameOver; drives a blink output for the player sprite.

Parameters:
- START_LIFE, 3, life value issued on level start
- MAX_LIFE, 5, heal ceiling
- ENEMY_DMG, 1, damage per enemy hit
- SPELL_DMG, 2, damage per spell hit
- POTION_HEAL, 1, life per potion
- INVULN_FRAMES, 60, frames of invulnerability after a remove
- BLINK_FRAMES, 4, frames per blink half-period

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- hitEnemy  in  1  one-cycle enemy collision pulse
- hitSpell  in  1  one-cycle spell collision pulse
- pickupPotion  in  1  one-cycle potion pulse
- levelStart  in  1  one-cycle level (re)start pulse
- currLife  in  3  life value fed back from tracker
- amount  out  3  command amount, valid with an enable
- enableSetLife  out  1  set command pulse
- enableAddLife  out  1  add command pulse
- enableRemoveLife  out  1  remove command pulse
- invulnerable  out  1  high while invulnerability counter is nonzero
- blink  out  1  sprite blink, toggling while invulnerable
- gameOver  out  1  sticky, life reached 0

Behaviour:
- Reset is asynchronous, active-low. While in reset or after it:
  - all outputs are 0.
  - pending registers, invulnerability counter and blink phase are cleared.
  - FSM goes to IDLE.
  - No SET command is issued at reset.
- Clock is clk; all state updates on its rising edge.
- Event capture each cycle (registered):
  - levelStart sets pendStart.
  - hitEnemy/hitSpell add ENEMY_DMG/SPELL_DMG to pendDmg, saturating at 7.
  - Hits are discarded if invulnerable=1 or gameOver=1.
  - pickupPotion adds POTION_HEAL to pendHeal, saturating at 7.
  - Potions are discarded if gameOver=1.
- Clear-then-set: an event arriving in the cycle its pending register is consumed is retained.
- FSM has three states: IDLE, SETTLE, CHECK. At most one enable is high per cycle; enables are one-hot and last 1 cycle.
- IDLE acts on pending work in priority order (start > damage > heal):
  - pendStart: issue SET, amount=START_LIFE. Clear pendStart, pendDmg, pendHeal, the invulnerability counter and gameOver. Go to SETTLE.
  - else pendDmg!=0 and !invulnerable: issue REMOVE, amount=pendDmg. Clear pendDmg. Load counter=INVULN_FRAMES and blink phase=1. Go to SETTLE.
  - else pendHeal!=0: compute room = MAX_LIFE - currLife (0 if currLife>=MAX_LIFE), then amount = min(pendHeal, room). Clear pendHeal.
    - If amount=0, issue no enable and stay in IDLE.
    - Otherwise issue ADD and go to SETTLE.
  - else: stay in IDLE.
- SETTLE: one idle cycle so currLife reflects the command; go to CHECK.
- CHECK: if currLife==0, set gameOver=1. Go to IDLE.
- Command latency: 1 cycle from the event pulse to pending, and 1 more to the enable when IDLE. Minimum spacing between commands is 3 cycles.
- Invulnerability counter: decrements on startOfFrame while nonzero; invulnerable = (counter != 0).
- Blink: toggles every BLINK_FRAMES startOfFrame pulses while invulnerable; it is 0 when not invulnerable.
- gameOver is sticky until a SET command or reset. While gameOver=1, only levelStart produces a command.
- Reset mid-command (any state): FSM returns to IDLE and any in-flight enable is deasserted immediately.

Test Plan:
- Reset, then hitEnemy -> 2 cycles later enableRemoveLife=1, amount=1 for 1 cycle; invulnerable=1; after 60 startOfFrame pulses invulnerable=0.
- hitEnemy and hitSpell in the same cycle -> single REMOVE with amount=3; a second hitSpell during invulnerability produces no command.
- currLife=4, three potions in consecutive cycles -> ADD amount=1 (clamped); later potions with currLife=5 produce no enable.
- currLife=2, hitSpell -> REMOVE amount=2 -> currLife=0 -> gameOver=1 in CHECK. Further hits and potions are ignored; levelStart -> SET amount=3 and gameOver=0.
- levelStart, hitEnemy and pickupPotion in the same cycle -> only SET amount=3; damage and heal pendings are dropped, invulnerable=0.
- Drop resetN while in SETTLE with invulnerable=1 -> all outputs 0 immediately. After release, hitEnemy is accepted normally.
